// File: rtl/fir_out_decimator.sv
// Output stage of the 4-tap FIR: rounds, shifts and saturates the accumulator, keeps every
// DECIM-th sample, and queues kept samples in a small FIFO behind a valid/ready port.
module fir_out_decimator #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               sat_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned SUM_W = IN_W + 1;
    localparam logic [SUM_W-1:0] RND =
        (SHIFT > 0) ? (SUM_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [SUM_W-1:0] MAX_OUT = SUM_W'({OUT_W{1'b1}});

    logic [PH_W-1:0]  phase;
    logic             stg_valid;
    logic [OUT_W-1:0] stg_data;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             keep;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rounded;
    logic             sat;
    logic [OUT_W-1:0] result;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [LVL_W-1:0] level_next;
    logic [PTR_W-1:0] rd_next;
    logic [OUT_W-1:0] head_next;

    // Sample selection and scaling; one extra bit keeps the rounding add from wrapping
    always_comb begin
        keep    = in_valid && (phase == '0);
        sum     = {1'b0, in_data} + RND;
        rounded = sum >> SHIFT;
        sat     = rounded > MAX_OUT;
        result  = sat ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
    end

    // FIFO control; a push into a full FIFO is allowed when the head leaves the same cycle
    always_comb begin
        full       = level == LVL_W'(DEPTH);
        pop        = out_valid && out_ready;
        push       = stg_valid && (!full || pop);
        drop       = stg_valid && full && !pop;
        level_next = level + LVL_W'(push) - LVL_W'(pop);
        rd_next    = rd_ptr + PTR_W'(pop);
        head_next  = (push && (wr_ptr == rd_next)) ? stg_data : mem[rd_next];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
            sat_count <= '0;
        end else if (clear) begin
            phase     <= '0;
            stg_valid <= 1'b0;
            stg_data  <= '0;
            sat_count <= '0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            end
            stg_valid <= keep;
            if (keep) begin
                stg_data <= result;
            end
            if (keep && sat && (sat_count != 8'hFF)) begin
                sat_count <= sat_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= stg_data;
        end
    end

    // Pointers, occupancy and a registered copy of the head entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_next;
            level     <= level_next;
            out_valid <= level_next != '0;
            if (level_next != '0) begin
                out_data <= head_next;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: four instances with different SHIFT/DECIM settings,
// a vector table for the streaming cases and hand-written sequences for FIFO and reset corners.
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        iv   [4];
    logic [31:0] id   [4];
    logic        rdy  [4];
    logic        ov   [4];
    logic [15:0] od   [4];
    logic [3:0]  lv   [4];
    logic        ovf  [4];
    logic [7:0]  sc   [4];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        int unsigned inst;
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  el;
    } vec_t;

    vec_t        vt [$];
    vec_t        row;
    logic [31:0] s2_in  [4];
    logic [15:0] s2_exp [4];
    int unsigned got    [$];

    always #5 clk = ~clk;

    fir_out_decimator #(.IN_W(32), .OUT_W(16), .SHIFT(0), .DECIM(4), .DEPTH(8)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(rdy[0]), .level(lv[0]),
        .overflow(ovf[0]), .sat_count(sc[0]));
    fir_out_decimator #(.IN_W(32), .OUT_W(16), .SHIFT(2), .DECIM(1), .DEPTH(8)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(rdy[1]), .level(lv[1]),
        .overflow(ovf[1]), .sat_count(sc[1]));
    fir_out_decimator #(.IN_W(32), .OUT_W(16), .SHIFT(0), .DECIM(1), .DEPTH(8)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ready(rdy[2]), .level(lv[2]),
        .overflow(ovf[2]), .sat_count(sc[2]));
    fir_out_decimator #(.IN_W(32), .OUT_W(16), .SHIFT(0), .DECIM(3), .DEPTH(8)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_data(od[3]), .out_ready(rdy[3]), .level(lv[3]),
        .overflow(ovf[3]), .sat_count(sc[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int unsigned i, input string tag);
        chk($sformatf("%s_u%0d_out_valid", tag, i), 32'(ov[i]), 0);
        chk($sformatf("%s_u%0d_out_data", tag, i), 32'(od[i]), 0);
        chk($sformatf("%s_u%0d_level", tag, i), 32'(lv[i]), 0);
        chk($sformatf("%s_u%0d_overflow", tag, i), 32'(ovf[i]), 0);
        chk($sformatf("%s_u%0d_sat_count", tag, i), 32'(sc[i]), 0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i]  = 1'b0;
            id[i]  = '0;
            rdy[i] = 1'b0;
        end
        #12;
        for (int unsigned i = 0; i < 4; i++) chk_zero(i, "reset");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // DECIM=4 stream: keep 10,50,90, each visible two cycles after its input cycle
        for (int i = 0; i < 14; i++) begin
            row.inst = 0;
            row.v    = (i < 12);
            row.d    = 32'(10 * (i + 1));
            row.r    = 1'b1;
            row.ev   = (i == 1) || (i == 5) || (i == 9);
            row.ed   = (i == 1) ? 16'd10 : (i == 5) ? 16'd50 : 16'd90;
            row.el   = row.ev ? 4'd1 : 4'd0;
            vt.push_back(row);
        end
        // SHIFT=2 rounding: 5->1, 6->2, 7->2, 0x3FFFF->0x10000 saturates to 0xFFFF
        s2_in[0] = 32'd5;  s2_in[1] = 32'd6;  s2_in[2] = 32'd7;  s2_in[3] = 32'h3FFFF;
        s2_exp[0] = 16'd1; s2_exp[1] = 16'd2; s2_exp[2] = 16'd2; s2_exp[3] = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            row.inst = 1;
            row.v    = (i < 4);
            row.d    = (i < 4) ? s2_in[i] : 32'd0;
            row.r    = 1'b1;
            row.ev   = (i >= 1) && (i <= 4);
            row.ed   = row.ev ? s2_exp[i-1] : 16'd0;
            row.el   = row.ev ? 4'd1 : 4'd0;
            vt.push_back(row);
        end

        foreach (vt[k]) begin
            iv[vt[k].inst]  = vt[k].v;
            id[vt[k].inst]  = vt[k].d;
            rdy[vt[k].inst] = vt[k].r;
            tick();
            chk($sformatf("vec%0d_out_valid", k), 32'(ov[vt[k].inst]), 32'(vt[k].ev));
            if (vt[k].ev) chk($sformatf("vec%0d_out_data", k), 32'(od[vt[k].inst]), 32'(vt[k].ed));
            chk($sformatf("vec%0d_level", k), 32'(lv[vt[k].inst]), 32'(vt[k].el));
        end
        chk("shift2_sat_count", 32'(sc[1]), 1);

        // SHIFT=0: 0x10000 exceeds 16 bits and saturates
        rdy[2] = 1'b1;
        iv[2] = 1'b1; id[2] = 32'h0001_0000;
        tick();
        iv[2] = 1'b0;
        tick();
        chk("sat16_out_valid", 32'(ov[2]), 1);
        chk("sat16_out_data", 32'(od[2]), 32'hFFFF);
        chk("sat16_sat_count", 32'(sc[2]), 1);
        tick();

        // Overfill: 10 samples with consumer stalled, last two are dropped
        rdy[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            iv[2] = 1'b1; id[2] = 32'(c + 1);
            tick();
        end
        iv[2] = 1'b0;
        tick();
        tick();
        chk("ovfill_level", 32'(lv[2]), 8);
        chk("ovfill_overflow", 32'(ovf[2]), 1);
        rdy[2] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            chk($sformatf("drain%0d_out_valid", j), 32'(ov[2]), 1);
            chk($sformatf("drain%0d_out_data", j), 32'(od[2]), 32'(j));
            tick();
        end
        chk("drain_level", 32'(lv[2]), 0);
        chk("drain_out_valid", 32'(ov[2]), 0);
        chk("drain_overflow_sticky", 32'(ovf[2]), 1);

        // DECIM=3 with gaps: only the 1st, 4th and 7th valid samples are kept
        rdy[3] = 1'b1;
        got.delete();
        for (int c = 0; c < 24; c++) begin
            iv[3] = (c < 18) && (c % 2 == 0);
            id[3] = 32'(c / 2 + 1);
            if (ov[3]) got.push_back(32'(od[3]));
            tick();
        end
        chk("decim3_count", got.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("decim3_item%0d", j), (j < got.size()) ? got[j] : 32'hDEAD, 32'(1 + 3 * j));
        end

        // Synchronous clear discards the coinciding sample and zeros everything
        rdy[2] = 1'b0;
        clear = 1'b1; iv[2] = 1'b1; id[2] = 32'd42;
        tick();
        clear = 1'b0; iv[2] = 1'b0;
        chk_zero(2, "clear2");
        tick();
        tick();
        chk("clear2_discard_valid", 32'(ov[2]), 0);
        chk("clear2_discard_level", 32'(lv[2]), 0);

        // Full FIFO at full rate: one push and one pop per cycle, nothing lost
        for (int c = 0; c < 21; c++) begin
            iv[2]  = 1'b1;
            id[2]  = 32'(101 + c);
            rdy[2] = (c >= 9);
            if (c >= 9) begin
                chk($sformatf("fullrate%0d_out_valid", c), 32'(ov[2]), 1);
                chk($sformatf("fullrate%0d_level", c), 32'(lv[2]), 8);
                chk($sformatf("fullrate%0d_out_data", c), 32'(od[2]), 32'(101 + c - 9));
            end
            tick();
        end
        iv[2] = 1'b0;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (ov[2]) got.push_back(32'(od[2]));
            tick();
        end
        chk("fullrate_overflow", 32'(ovf[2]), 0);
        chk("fullrate_tail_count", got.size(), 9);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("fullrate_tail%0d", j), (j < got.size()) ? got[j] : 32'hDEAD, 32'(113 + j));
        end

        // Async reset mid-stream with 5 entries queued and phase mid-count
        rdy[0] = 1'b0;
        for (int c = 0; c < 18; c++) begin
            iv[0] = 1'b1; id[0] = 32'(200 + c);
            tick();
        end
        iv[0] = 1'b0;
        tick();
        tick();
        chk("prereset_level", 32'(lv[0]), 5);
        chk("prereset_out_data", 32'(od[0]), 200);
        #3;
        reset = 1'b1;
        #1;
        chk_zero(0, "midreset");
        #2;
        reset = 1'b0;
        iv[0] = 1'b1; id[0] = 32'd777;
        tick();
        iv[0] = 1'b0;
        tick();
        chk("postreset_out_valid", 32'(ov[0]), 1);
        chk("postreset_out_data", 32'(od[0]), 777);
        chk("postreset_level", 32'(lv[0]), 1);

        // Same scenario with clear: effect only at the clock edge
        for (int c = 0; c < 17; c++) begin
            iv[0] = 1'b1; id[0] = 32'(300 + c);
            tick();
        end
        iv[0] = 1'b0;
        tick();
        tick();
        chk("preclear_level", 32'(lv[0]), 5);
        chk("preclear_out_data", 32'(od[0]), 777);
        clear = 1'b1; iv[0] = 1'b1; id[0] = 32'd999;
        #1;
        chk("clear_is_sync_level", 32'(lv[0]), 5);
        tick();
        clear = 1'b0; iv[0] = 1'b0;
        chk_zero(0, "midclear");
        iv[0] = 1'b1; id[0] = 32'd555;
        tick();
        iv[0] = 1'b0;
        tick();
        chk("postclear_out_valid", 32'(ov[0]), 1);
        chk("postclear_out_data", 32'(od[0]), 555);
        chk("postclear_level", 32'(lv[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
- Downstream stage of the 4-tap FIR filter.
- Consumes the FIR's full-precision 32-bit accumulator, applies a round-half-up right shift and unsigned saturation to 16 bits, and keeps every DECIM-th sample.
- Buffers kept samples in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Reports saturation events and dropped samples.

Parameters:
- IN_W, 32, input sample width (unsigned, matches FIR accumulator)
- OUT_W, 16, output sample width (unsigned)
- SHIFT, 0, right-shift applied before saturation (0..IN_W-1)
- DECIM, 4, decimation factor (>=1; 1 = keep every sample)
- DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush: phase, pipeline, FIFO, flags
- in_valid  input  1  in_data valid this cycle (no backpressure upstream)
- in_data  input  IN_W  unsigned FIR accumulator value
- out_valid  output  1  FIFO head valid
- out_data  output  OUT_W  FIFO head sample
- out_ready  input  1  consumer accepts head when out_valid && out_ready
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: a kept sample was dropped because the FIFO was full
- sat_count  output  8  number of saturated kept samples, saturates at 255

Behaviour:
- Reset (async) and clear (sync, priority over all other activity):
  - phase=0; stage register invalid; FIFO empty.
  - out_valid=0, out_data=0, level=0, overflow=0, sat_count=0.
  - A sample arriving in the same cycle as clear is discarded.
- Phase counter:
  - Increments on every in_valid and wraps DECIM-1 -> 0.
  - A sample is kept iff in_valid && phase==0, so the first valid sample after reset/clear is kept.
  - Cycles with in_valid=0 do not advance phase.
- Scaling of a kept sample, computed in IN_W+1 bits so it never wraps:
  - rounded = (in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT.
  - If rounded > 2^OUT_W-1: result = all ones and sat_count += 1 (stops at 255).
  - Otherwise result = rounded[OUT_W-1:0].
  - Result is registered into the stage register with a valid bit at the edge ending the input cycle.
- FIFO write:
  - A valid stage register is written at the next edge.
  - Latency: in_valid (kept) in cycle k -> out_valid=1 and out_data=result in cycle k+2 when the FIFO was empty.
  - Stage register accepts a new sample every cycle (DECIM=1 sustains full rate).
- FIFO read:
  - out_data = entry at read pointer; out_valid = (level!=0).
  - Pop on out_valid && out_ready.
  - out_data is undefined when out_valid=0 except after reset/clear, where it is 0.
- Pointers: read and write pointers wrap modulo DEPTH. level tracks pushes minus pops.
- Simultaneous events:
  - Push and pop, not full: both occur, level unchanged.
  - Push while full and pop in the same cycle: both occur, no drop, level stays DEPTH.
  - Push while full, no pop: sample dropped, FIFO contents unchanged, overflow<=1 until reset/clear.
  - A dropped sample that saturated still increments sat_count.
- out_ready is ignored when out_valid=0; level never underflows.
- FIFO ordering is strictly first-in first-out; no reordering or duplication.

Test Plan:
- SHIFT=0, DECIM=4, out_ready=1, in_valid=1 continuously, in_data=10,20,30,...,120 -> out_data sequence 10,50,90; first out_valid two cycles after the first input cycle.
- SHIFT=2, DECIM=1, in_data=5,6,7,0x3FFFF -> out_data 1,2,2,0xFFFF; sat_count=1. Then SHIFT=0, in_data=0x0001_0000 -> 0xFFFF, sat_count increments.
- DECIM=1, DEPTH=8, out_ready=0, 10 consecutive samples 1..10 -> level=8, overflow=1. Then out_ready=1 -> drains 1..8 in order, level returns to 0, overflow stays 1.
- FIFO full with out_ready=1 and in_valid=1 every cycle (DECIM=1) -> one push and one pop per cycle, level=8 constant, overflow stays 0, no samples lost.
- DECIM=3 with in_valid toggling 1,0,1,0,... on data 1..9 -> kept samples 1,4,7 only; gaps do not advance phase.
- Reset asserted mid-stream with FIFO holding 5 entries -> all outputs 0 immediately (async). After release, the first valid sample is kept. Repeat with clear: same result, synchronous.
